rs15_9_encoder: RTL

Sequential systematic Reed-Solomon RS(15,9) encoder over GF(16), primitive polynomial x^4+x+1, correcting up to 3 symbol errors. It produces the codewords consumed by the team's RS(15,9) decoder: same symbol packing, same field, generator roots alpha^1..alpha^6. The encoder uses a 6-stage LFSR and shifts one message symbol per clock, so one codeword takes 9 shift cycles.

---
 rtl/rs_pkg.sv | 49 ++++
 rtl/gf16_const_mul.sv | 23 ++
 rtl/rs15_9_encoder.sv | 96 +++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared RS(15,9) definitions over GF(16), primitive polynomial x^4+x+1.
// Used by both the encoder and the decoder so the two sides agree on field,
// code dimensions and generator polynomial.
//   N, K, NPAR    : code length, message length, parity symbol count
//   GF_EXP        : alpha^i table, alpha = 0x2
//   G0..G5, G_VEC : generator coefficients g(x) = x^6 + G5 x^5 + ... + G0
//   gf16_mul      : polynomial-basis GF(16) product
//   enc_state_t   : encoder FSM states
package rs_pkg;

    localparam int N    = 15;
    localparam int K    = 9;
    localparam int NPAR = 6;

    localparam logic [3:0] GF_EXP [0:14] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    // g(x) = (x - a^1)(x - a^2)...(x - a^6)
    localparam logic [3:0] G5 = 4'h7;  // a^10
    localparam logic [3:0] G4 = 4'h9;  // a^14
    localparam logic [3:0] G3 = 4'h3;  // a^4
    localparam logic [3:0] G2 = 4'hC;  // a^6
    localparam logic [3:0] G1 = 4'hA;  // a^9
    localparam logic [3:0] G0 = 4'hC;  // a^6

    localparam logic [23:0] G_VEC = {G5, G4, G3, G2, G1, G0};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } enc_state_t;

    // Shift-and-add multiply; x^4 folds back as x + 1 (0x3).
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[3] ? ({sh[2:0], 1'b0} ^ 4'h3) : {sh[2:0], 1'b0};
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf16_const_mul.sv
// Multiply a GF(16) symbol by a fixed coefficient.
//   COEF : constant multiplier (parameter)
//   a    : 4-bit input symbol
//   p    : 4-bit product a * COEF
// Every column of the product matrix is a constant, so this reduces to a
// pure XOR network once synthesis folds the constants.
module gf16_const_mul
    import rs_pkg::*;
#(
    parameter logic [3:0] COEF = 4'h1
) (
    input  logic [3:0] a,
    output logic [3:0] p
);

    always_comb begin
        p = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (a[k]) p = p ^ gf16_mul(COEF, 4'(1 << k));
        end
    end

endmodule

// File: rtl/rs15_9_encoder.sv
// Systematic RS(15,9) encoder, one message symbol per clock through a
// 6-stage LFSR that divides m(x)*x^6 by g(x).
//   clk           : clock, rising edge
//   rst           : synchronous active-high reset
//   messageIn     : 9 symbols, symbol k at [4k+3:4k]
//   encodeMessage : start strobe, honoured only in IDLE
//   codeWordOut   : 15 symbols, message in [59:24], parity in [23:0]
//   codeWordValid : one-cycle pulse when codeWordOut is refreshed
//   encoderBusy   : high from start until the valid cycle has passed
module rs15_9_encoder
    import rs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] messageIn,
    input  logic        encodeMessage,
    output logic [59:0] codeWordOut,
    output logic        codeWordValid,
    output logic        encoderBusy
);

    enc_state_t  state;
    enc_state_t  state_next;
    logic        load;
    logic        shift_en;
    logic        done;

    logic [35:0] msg_sr;
    logic [3:0]  par [0:5];
    logic [3:0]  cnt;
    logic [3:0]  fb;
    logic [3:0]  fb_prod [0:5];

    // Highest remaining message symbol sits in the top nibble.
    assign fb = msg_sr[35:32] ^ par[5];

    for (genvar j = 0; j < 6; j++) begin : g_mul
        gf16_const_mul #(.COEF(G_VEC[4*j +: 4])) u_mul (
            .a (fb),
            .p (fb_prod[j])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (encodeMessage) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == 4'd8)   state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load     = (state == ST_IDLE) && encodeMessage;
        shift_en = (state == ST_SHIFT);
        done     = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_sr        <= '0;
            cnt           <= '0;
            codeWordOut   <= '0;
            codeWordValid <= 1'b0;
            encoderBusy   <= 1'b0;
            for (int j = 0; j < 6; j++) par[j] <= 4'h0;
        end else begin
            if (load) begin
                msg_sr <= messageIn;
                cnt    <= '0;
                for (int j = 0; j < 6; j++) par[j] <= 4'h0;
            end
            if (shift_en) begin
                // Rotate rather than shift: after 9 steps the register holds
                // the original message again, ready for the codeword.
                msg_sr <= {msg_sr[31:0], msg_sr[35:32]};
                cnt    <= cnt + 4'd1;
                par[0] <= fb_prod[0];
                for (int j = 1; j < 6; j++) par[j] <= par[j-1] ^ fb_prod[j];
            end
            if (done) begin
                codeWordOut <= {msg_sr, par[5], par[4], par[3], par[2], par[1], par[0]};
            end
            codeWordValid <= done;
            // Busy covers the valid cycle too, since DONE cannot accept a start.
            encoderBusy   <= (state_next != ST_IDLE) || done;
        end
    end

endmodule
